fetch_unit: RTL
===============

# fetch_unit

Instruction fetch stage sitting directly upstream of the 16×16 register bank.
- Reads the PC from the bank's `pc_data_out` and fetches the 16-bit instruction from instruction memory over a req/ready handshake.
- Presents the instruction's register fields to the bank and writes back the next PC through `pc_data_in`/`pc_inc`.
- Handles stalls, taken branches and collisions with the bank's write port, which has priority over `pc_inc`.

## Interface
- `PC_STEP`, 2, PC increment per sequential fetch (byte-addressed 16-bit words).
- `SETTLE_CYCLES`, 2, cycles waited after a PC update before `pc_data_out` is trusted (bank output is registered one edge after its write); legal range 1–7.
- `clk`  in  1  system clock; all state changes on rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `pc_data_out`  in  16  current PC from register bank.
- `wr_en`  in  1  bank write-port enable; when high, the bank ignores `pc_inc` that cycle.
- `mem_rdata`  in  16  instruction word from instruction memory.
- `mem_ready`  in  1  memory handshake complete; `mem_rdata` valid this cycle.
- `stall`  in  1  hold off starting a new fetch.
- `branch_en`  in  1  one-cycle request to redirect the PC.
- `branch_target`  in  16  redirect address, sampled when `branch_en` is high.
- `mem_req`  out  1  instruction read request.
- `mem_addr`  out  16  instruction read address.
- `pc_data_in`  out  16  next PC value to the bank.
- `pc_inc`  out  1  PC write strobe to the bank.
- `instr`  out  16  last fetched instruction.
- `instr_valid`  out  1  one-cycle pulse: new `instr` available.
- `src_reg`  out  4  `instr[11:8]`, registered with `instr`.
- `dst_reg`  out  4  `instr[7:4]`, registered with `instr`.

## Operation
- FSM states: SETTLE, REQ, UPDATE.
- **SETTLE**
  - 3-bit counter counts `SETTLE_CYCLES`.
  - On expiry with `stall`=0: latch `pc_data_out` into `mem_addr`, go to REQ.
  - If `stall`=1 at expiry: remain in SETTLE with the counter saturated.
- **REQ**
  - `mem_req`=1 and `mem_addr` are held stable until `mem_ready`=1.
  - On `mem_ready`: capture `mem_rdata` into `instr` and the decoded fields into `src_reg`/`dst_reg`, then go to UPDATE.
  - `stall` is ignored once REQ is entered.
- **UPDATE**
  - `pc_inc`=1.
  - `pc_data_in` = pending branch target if a branch is pending, else `mem_addr + PC_STEP`, truncated to 16 bits (0xFFFE + 2 = 0x0000).
  - If `wr_en`=1 this cycle: the bank dropped the write, so stay in UPDATE and reassert next cycle with the same `pc_data_in`.
  - Else: clear the pending branch, reload the counter, go to SETTLE.
- **Branch pending**
  - `branch_en` in any state sets the pending flag and latches `branch_target`.
  - A later `branch_en` before consumption overwrites the target (last wins).
  - `branch_en` in the same cycle as a successful UPDATE is used by that UPDATE, not deferred.
- **Reset** (`rst`=0, any state, including mid-handshake)
  - Immediately: `mem_req`=0, `pc_inc`=0, `instr_valid`=0.
  - `mem_addr`, `pc_data_in`, `instr`, `src_reg`, `dst_reg` = 0.
  - Pending branch cleared; state = SETTLE with counter reloaded.
  - A dropped request is not completed; memory must tolerate `mem_req` falling without `mem_ready`.

## Timing
- `mem_req` is registered: high from the first cycle in REQ.
- Zero-wait memory (`mem_ready` high in the first REQ cycle): one REQ cycle.
- `instr`, `src_reg`, `dst_reg` update on the edge that leaves REQ. `instr_valid` is high for exactly the following cycle, which coincides with the first UPDATE cycle.
- `pc_inc` high for exactly one cycle per fetch when `wr_en`=0, or N+1 cycles when `wr_en` blocks it N times.
- Sequential throughput, zero-wait memory, no stalls or collisions: one instruction per `SETTLE_CYCLES + 2` cycles (4 at defaults).
- First `mem_req` after reset release: cycle `SETTLE_CYCLES + 1`.

## Test plan
- Reset, bank PC = 0x0000, zero-wait memory returning 0x1234:
  - `mem_req` first asserted in cycle 3 with `mem_addr`=0x0000.
  - `instr`=0x1234, `src_reg`=2, `dst_reg`=3.
  - `pc_inc` pulse with `pc_data_in`=0x0002.
  - Next fetch at 0x0002.
- PC 0xFFFE: `pc_data_in`=0x0000 (wrap).
- `mem_ready` delayed 5 cycles: `mem_req`/`mem_addr` stable for all 5 cycles; `instr_valid` pulses once.
- `wr_en`=1 during the first two UPDATE cycles: `pc_inc` high 3 consecutive cycles, `pc_data_in` constant, single PC advance.
- `branch_en` with target 0x0400 during REQ at 0x0010: `pc_data_in`=0x0400 (not 0x0012); the following fetch uses `mem_addr`=0x0400.
- `rst` low mid-REQ: same cycle `mem_req`=0 and all outputs zero; after release, fetch restarts from the bank PC with no `instr_valid` for the aborted fetch.

Source files
------------

// File: rtl/fetch_unit_if.sv
// ---------------------------------------------------------------------------
// Module   : fetch_unit_if
// Brief    : Instruction-memory read handshake (req/ready) between fetch and memory.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

interface fetch_unit_if;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic [15:0] mem_rdata;
    logic        mem_ready;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_rdata,
        input  mem_ready
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_rdata,
        output mem_ready
    );
endinterface

`default_nettype wire

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// Module   : fetch_unit
// Brief    : Fetch stage: reads PC from the register bank, fetches one 16-bit
//            instruction over req/ready and writes back the next PC.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module fetch_unit #(
    parameter int PC_STEP       = 2,
    parameter int SETTLE_CYCLES = 2
) (
    input  wire logic        clk,
    input  wire logic        rst,
    fetch_unit_if.master     mem,
    input  wire logic [15:0] pc_data_out,
    input  wire logic        wr_en,
    input  wire logic        stall,
    input  wire logic        branch_en,
    input  wire logic [15:0] branch_target,
    output logic      [15:0] pc_data_in,
    output logic             pc_inc,
    output logic      [15:0] instr,
    output logic             instr_valid,
    output logic      [3:0]  src_reg,
    output logic      [3:0]  dst_reg
);

    localparam logic [2:0]  c_settle_reload = 3'(SETTLE_CYCLES - 1);
    localparam logic [15:0] c_pc_step       = 16'(PC_STEP);

    typedef enum logic [1:0] {
        SETTLE = 2'd0,
        REQ    = 2'd1,
        UPDATE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [2:0]  r_cnt;
    logic [2:0]  w_cnt_nxt;
    logic [15:0] r_mem_addr;
    logic [15:0] w_addr_nxt;
    logic        r_mem_req;
    logic        r_pc_inc;
    logic        r_instr_valid;
    logic [15:0] r_instr;
    logic [3:0]  r_src_reg;
    logic [3:0]  r_dst_reg;
    logic        r_br_pend;
    logic [15:0] r_br_target;
    logic        w_capture;
    logic        w_update_ok;
    logic [15:0] w_next_pc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= SETTLE;
            r_cnt   <= c_settle_reload;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Counter saturates at zero, so a stall released late starts the fetch on the next edge.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_addr_nxt  = r_mem_addr;
        w_capture   = 1'b0;
        w_update_ok = 1'b0;
        case (r_state)
            SETTLE: begin
                if (r_cnt != 3'd0) begin
                    w_cnt_nxt = r_cnt - 3'd1;
                end else if (!stall) begin
                    w_addr_nxt  = pc_data_out;
                    w_state_nxt = REQ;
                end
            end
            REQ: begin
                if (mem.mem_ready) begin
                    w_capture   = 1'b1;
                    w_state_nxt = UPDATE;
                end
            end
            UPDATE: begin
                if (!wr_en) begin
                    w_update_ok = 1'b1;
                    w_cnt_nxt   = c_settle_reload;
                    w_state_nxt = SETTLE;
                end
            end
            default: begin
                w_cnt_nxt   = c_settle_reload;
                w_state_nxt = SETTLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mem_req     <= 1'b0;
            r_mem_addr    <= '0;
            r_pc_inc      <= 1'b0;
            r_instr_valid <= 1'b0;
            r_instr       <= '0;
            r_src_reg     <= '0;
            r_dst_reg     <= '0;
            r_br_pend     <= 1'b0;
            r_br_target   <= '0;
        end else begin
            r_mem_req     <= (w_state_nxt == REQ);
            r_mem_addr    <= w_addr_nxt;
            r_pc_inc      <= (w_state_nxt == UPDATE);
            r_instr_valid <= w_capture;
            if (w_capture) begin
                r_instr   <= mem.mem_rdata;
                r_src_reg <= mem.mem_rdata[11:8];
                r_dst_reg <= mem.mem_rdata[7:4];
            end
            // A branch arriving with a successful update is consumed by it, not deferred.
            if (w_update_ok) begin
                r_br_pend <= 1'b0;
            end else if (branch_en) begin
                r_br_pend   <= 1'b1;
                r_br_target <= branch_target;
            end
        end
    end

    assign w_next_pc = branch_en ? branch_target :
                       r_br_pend ? r_br_target   :
                                   r_mem_addr + c_pc_step;

    assign mem.mem_req  = r_mem_req;
    assign mem.mem_addr = r_mem_addr;
    assign pc_inc       = r_pc_inc;
    assign pc_data_in   = r_pc_inc ? w_next_pc : 16'h0000;
    assign instr        = r_instr;
    assign instr_valid  = r_instr_valid;
    assign src_reg      = r_src_reg;
    assign dst_reg      = r_dst_reg;

endmodule

`default_nettype wire
